// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer: sync hunt, command decode and per-row distribution
// of configuration frame words, followed by a one-cycle frame commit strobe.
// Optional build macro: CONFIG_FRAME_CHECKSUM_EN adds a trailing XOR checksum
// word to every frame; a mismatch drops the frame and raises Error_O.
module config_frame_sequencer #(
  parameter int          FRAME_BITS_PER_ROW = 32,
  parameter int          ROW_SELECT_WIDTH   = 5,
  parameter int          NUM_ROWS           = 16,
  parameter int          FRAME_ADDR_WIDTH   = 16,
  parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [31:0]                   WordData_I,
  input  logic                          WordValid_I,
  output logic                          WordReady_O,
  output logic [FRAME_BITS_PER_ROW-1:0] FrameData_O,
  output logic [ROW_SELECT_WIDTH-1:0]   RowSelect_O,
  output logic [FRAME_ADDR_WIDTH-1:0]   FrameAddr_O,
  output logic                          FrameStrobe_O,
  output logic                          Busy_O,
  output logic                          Error_O
);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_COMMIT1 = 3'd3;
  localparam logic [2:0] S_COMMIT2 = 3'd4;

  localparam logic [7:0] OP_DESYNC = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;

  // One extra counter bit so the checksum slot (NUM_ROWS+1) never wraps.
  localparam int             CW       = ROW_SELECT_WIDTH + 1;
  localparam logic [CW-1:0]  ROW_ONE  = CW'(1);
  localparam logic [CW-1:0]  LAST_ROW = CW'(NUM_ROWS);
`ifdef CONFIG_FRAME_CHECKSUM_EN
  localparam logic [CW-1:0]  CSUM_ROW = CW'(NUM_ROWS + 1);
`endif

  logic [2:0]                    state, state_nxt;
  logic [CW-1:0]                 row_cnt, row_cnt_nxt;
  logic [FRAME_BITS_PER_ROW-1:0] data_nxt;
  logic [ROW_SELECT_WIDTH-1:0]   rsel_nxt;
  logic [FRAME_ADDR_WIDTH-1:0]   addr_nxt;
  logic                          strobe_nxt;
  logic                          err_nxt;
  logic                          ready_state;
  logic                          accept;
  logic [7:0]                    opcode;
`ifdef CONFIG_FRAME_CHECKSUM_EN
  logic [31:0]                   csum, csum_nxt;
`endif

  // Ready is a pure state decode, forced low while reset is held.
  assign ready_state = (state == S_HUNT) || (state == S_CMD) || (state == S_DATA);
  assign WordReady_O = resetn & ready_state;
  assign accept      = WordValid_I & WordReady_O;
  assign opcode      = WordData_I[31:24];

  // Next-state and next-output decode; row select defaults to idle each cycle.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    data_nxt    = FrameData_O;
    rsel_nxt    = '0;
    addr_nxt    = FrameAddr_O;
    strobe_nxt  = 1'b0;
    err_nxt     = Error_O;
`ifdef CONFIG_FRAME_CHECKSUM_EN
    csum_nxt    = csum;
`endif
    case (state)
      S_HUNT: begin
        if (accept && (WordData_I == SYNC_WORD)) begin
          state_nxt = S_CMD;
          err_nxt   = 1'b0;
        end
      end
      S_CMD: begin
        if (accept) begin
          case (opcode)
            OP_WRITE: begin
              addr_nxt    = WordData_I[FRAME_ADDR_WIDTH-1:0];
              row_cnt_nxt = ROW_ONE;
              state_nxt   = S_DATA;
`ifdef CONFIG_FRAME_CHECKSUM_EN
              csum_nxt    = '0;
`endif
            end
            OP_DESYNC: state_nxt = S_HUNT;
            default: begin
              err_nxt   = 1'b1;
              state_nxt = S_HUNT;
            end
          endcase
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
          if (row_cnt == CSUM_ROW) begin
            // Checksum slot: no row is driven, frame data keeps the last row.
            if (WordData_I == csum) begin
              state_nxt = S_COMMIT1;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = S_HUNT;
            end
          end else begin
            data_nxt    = WordData_I;
            rsel_nxt    = row_cnt[ROW_SELECT_WIDTH-1:0];
            row_cnt_nxt = row_cnt + ROW_ONE;
            csum_nxt    = csum ^ WordData_I;
          end
`else
          data_nxt    = WordData_I;
          rsel_nxt    = row_cnt[ROW_SELECT_WIDTH-1:0];
          row_cnt_nxt = row_cnt + ROW_ONE;
          if (row_cnt == LAST_ROW) state_nxt = S_COMMIT1;
`endif
        end
      end
      // Last row is being captured downstream; strobe goes out next cycle.
      S_COMMIT1: begin
        state_nxt  = S_COMMIT2;
        strobe_nxt = 1'b1;
      end
      S_COMMIT2: state_nxt = S_CMD;
      default:   state_nxt = S_HUNT;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state         <= S_HUNT;
      row_cnt       <= ROW_ONE;
      FrameData_O   <= '0;
      RowSelect_O   <= '0;
      FrameAddr_O   <= '0;
      FrameStrobe_O <= 1'b0;
      Busy_O        <= 1'b0;
      Error_O       <= 1'b0;
    end else begin
      state         <= state_nxt;
      row_cnt       <= row_cnt_nxt;
      FrameData_O   <= data_nxt;
      RowSelect_O   <= rsel_nxt;
      FrameAddr_O   <= addr_nxt;
      FrameStrobe_O <= strobe_nxt;
      Busy_O        <= (state_nxt != S_HUNT);
      Error_O       <= err_nxt;
    end
  end

`ifdef CONFIG_FRAME_CHECKSUM_EN
  // Running XOR of the current frame's data words.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) csum <= '0;
    else         csum <= csum_nxt;
  end
`endif

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Directed bench for config_frame_sequencer: frame loads with and without
// stalls, bad opcodes, reset mid-frame, back-to-back frames and (when
// CONFIG_FRAME_CHECKSUM_EN is defined) checksum accept/reject.
module tb_config_frame_sequencer;
  localparam int          NR   = 16;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] WordData_I = '0;
  logic        WordValid_I = 1'b0;
  logic        WordReady_O;
  logic [31:0] FrameData_O;
  logic [4:0]  RowSelect_O;
  logic [15:0] FrameAddr_O;
  logic        FrameStrobe_O, Busy_O, Error_O;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [4:0]  rsel_q[$];
  logic [31:0] data_q[$];
  int          rcyc_q[$];
  int          scyc_q[$];
  logic [15:0] saddr_q[$];
`ifdef CONFIG_FRAME_CHECKSUM_EN
  bit          csum_bad = 1'b0;
`endif

  config_frame_sequencer dut (
    .CLK(CLK), .resetn(resetn),
    .WordData_I(WordData_I), .WordValid_I(WordValid_I), .WordReady_O(WordReady_O),
    .FrameData_O(FrameData_O), .RowSelect_O(RowSelect_O), .FrameAddr_O(FrameAddr_O),
    .FrameStrobe_O(FrameStrobe_O), .Busy_O(Busy_O), .Error_O(Error_O)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record row loads and strobes mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (RowSelect_O != 5'd0) begin
      rsel_q.push_back(RowSelect_O);
      data_q.push_back(FrameData_O);
      rcyc_q.push_back(cyc);
    end
    if (FrameStrobe_O) begin
      scyc_q.push_back(cyc);
      saddr_q.push_back(FrameAddr_O);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    rsel_q.delete(); data_q.delete(); rcyc_q.delete();
    scyc_q.delete(); saddr_q.delete();
  endtask

  task automatic idle(input int n);
    WordValid_I = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Offer one word and wait (bounded) for it to transfer.
  task automatic put(input logic [31:0] w);
    int n = 0;
    WordData_I  = w;
    WordValid_I = 1'b1;
    while (!WordReady_O && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (!WordReady_O) chk("put_timeout", {31'd0, WordReady_O}, 32'd1);
    else begin
      last_acc = cyc;
      @(posedge CLK); #1;
    end
    WordValid_I = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] base, input bit toggle);
`ifdef CONFIG_FRAME_CHECKSUM_EN
    logic [31:0] x = '0;
`endif
    for (int i = 0; i < NR; i++) begin
      put(base + i);
`ifdef CONFIG_FRAME_CHECKSUM_EN
      x ^= base + i;
`endif
      if (toggle && i != NR - 1) idle(1);
    end
`ifdef CONFIG_FRAME_CHECKSUM_EN
    put(csum_bad ? ~x : x);
`endif
  endtask

  // Cycle-exact COMMIT check, entered in the cycle after the final word.
  task automatic check_commit();
    chk("c1_ready", {31'd0, WordReady_O}, 32'd0);
`ifdef CONFIG_FRAME_CHECKSUM_EN
    chk("c1_rsel", {27'd0, RowSelect_O}, 32'd0);
`else
    chk("c1_rsel", {27'd0, RowSelect_O}, NR);
`endif
    chk("c1_strobe", {31'd0, FrameStrobe_O}, 32'd0);
    @(posedge CLK); #1;
    chk("c2_ready", {31'd0, WordReady_O}, 32'd0);
    chk("c2_strobe", {31'd0, FrameStrobe_O}, 32'd1);
    chk("c2_rsel", {27'd0, RowSelect_O}, 32'd0);
    @(posedge CLK); #1;
    chk("c3_ready", {31'd0, WordReady_O}, 32'd1);
    chk("c3_strobe", {31'd0, FrameStrobe_O}, 32'd0);
    chk("c3_busy", {31'd0, Busy_O}, 32'd1);
  endtask

  // Rows 1..NR with data base+i, spaced step cycles apart.
  task automatic check_rows(input int first, input logic [31:0] base, input int step);
    if (rsel_q.size() < first + NR) begin
      chk("rows_present", rsel_q.size(), first + NR);
    end else begin
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("row%0d_sel", i + 1), {27'd0, rsel_q[first + i]}, i + 1);
        chk($sformatf("row%0d_data", i + 1), data_q[first + i], base + i);
        chk($sformatf("row%0d_gap", i + 1), rcyc_q[first + i] - rcyc_q[first], step * i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #3 resetn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {31'd0, WordReady_O}, 32'd0);
    chk("rst_rsel", {27'd0, RowSelect_O}, 32'd0);
    chk("rst_data", FrameData_O, 32'd0);
    chk("rst_addr", {16'd0, FrameAddr_O}, 32'd0);
    chk("rst_flags", {29'd0, FrameStrobe_O, Busy_O, Error_O}, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rel_ready", {31'd0, WordReady_O}, 32'd1);
    clear_q();

    // Frame at address 7, valid held high
    put(SYNC);
    chk("sync_busy", {31'd0, Busy_O}, 32'd1);
    put(32'h0100_0007);
    send_data(32'hA000_0001, 1'b0);
    check_commit();
    idle(2);
    check_rows(0, 32'hA000_0001, 1);
    chk("f1_rowcnt", rsel_q.size(), NR);
    chk("f1_strobes", scyc_q.size(), 1);
    if (scyc_q.size() > 0) begin
      chk("f1_strobe_cyc", scyc_q[0], last_acc + 2);
      chk("f1_strobe_addr", {16'd0, saddr_q[0]}, 32'h7);
    end
    chk("f1_addr", {16'd0, FrameAddr_O}, 32'h7);
    chk("f1_err", {31'd0, Error_O}, 32'd0);

    // Same frame with valid toggling
    clear_q();
    put(32'h0100_0007);
    send_data(32'hA000_0001, 1'b1);
    check_commit();
    idle(2);
    check_rows(0, 32'hA000_0001, 2);
    chk("f2_rowcnt", rsel_q.size(), NR);
    chk("f2_strobes", scyc_q.size(), 1);
    put(32'h0000_0000);
    chk("desync_busy", {31'd0, Busy_O}, 32'd0);

    // Junk, sync, bad opcode, resync
    put(32'h1234_5678);
    chk("junk_busy", {31'd0, Busy_O}, 32'd0);
    put(SYNC);
    chk("e_sync_busy", {31'd0, Busy_O}, 32'd1);
    put(32'h0500_0000);
    chk("e_err", {31'd0, Error_O}, 32'd1);
    chk("e_busy", {31'd0, Busy_O}, 32'd0);
    chk("e_ready", {31'd0, WordReady_O}, 32'd1);
    put(SYNC);
    chk("e_clear", {31'd0, Error_O}, 32'd0);

    // Reset after the 9th data word
    clear_q();
    put(32'h0100_0009);
    for (int i = 0; i < 9; i++) put(32'hB000_0001 + i);
    chk("mid_rsel9", {27'd0, RowSelect_O}, 32'd9);
    resetn = 1'b0;
    #1;
    chk("mid_ready", {31'd0, WordReady_O}, 32'd0);
    chk("mid_rsel", {27'd0, RowSelect_O}, 32'd0);
    chk("mid_data", FrameData_O, 32'd0);
    chk("mid_addr", {16'd0, FrameAddr_O}, 32'd0);
    chk("mid_flags", {29'd0, FrameStrobe_O, Busy_O, Error_O}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_nostrobe", scyc_q.size(), 0);
    resetn = 1'b1;
    #1;
    clear_q();
    put(SYNC);
    put(32'h0100_000A);
    send_data(32'hB100_0001, 1'b0);
    check_commit();
    idle(1);
    check_rows(0, 32'hB100_0001, 1);
    chk("r_strobes", scyc_q.size(), 1);
    chk("r_addr", {16'd0, FrameAddr_O}, 32'hA);

    // Back-to-back frames at 3 and 4, then desync
    clear_q();
    put(32'h0100_0003);
    send_data(32'hC000_0001, 1'b0);
    check_commit();
    put(32'h0100_0004);
    send_data(32'hD000_0001, 1'b0);
    check_commit();
    put(32'h0000_0000);
    idle(2);
    check_rows(0, 32'hC000_0001, 1);
    check_rows(NR, 32'hD000_0001, 1);
    chk("bb_strobes", scyc_q.size(), 2);
    if (saddr_q.size() == 2) begin
      chk("bb_addr0", {16'd0, saddr_q[0]}, 32'h3);
      chk("bb_addr1", {16'd0, saddr_q[1]}, 32'h4);
    end
    chk("bb_busy", {31'd0, Busy_O}, 32'd0);

`ifdef CONFIG_FRAME_CHECKSUM_EN
    // Wrong checksum, then correct checksum
    clear_q();
    put(SYNC);
    put(32'h0100_0011);
    csum_bad = 1'b1;
    send_data(32'hE000_0001, 1'b0);
    chk("cs_err", {31'd0, Error_O}, 32'd1);
    chk("cs_busy", {31'd0, Busy_O}, 32'd0);
    idle(3);
    chk("cs_nostrobe", scyc_q.size(), 0);
    clear_q();
    put(SYNC);
    chk("cs_errclr", {31'd0, Error_O}, 32'd0);
    put(32'h0100_0011);
    csum_bad = 1'b0;
    send_data(32'hE000_0001, 1'b0);
    check_commit();
    idle(1);
    check_rows(0, 32'hE000_0001, 1);
    chk("cs_rowcnt", rsel_q.size(), NR);
    chk("cs_strobes", scyc_q.size(), 1);
    if (scyc_q.size() > 0) chk("cs_strobe_cyc", scyc_q[0], last_acc + 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
